mem_lut_search: RTL
===================

Name: mem_lut_search

Overview:
- Reverse lookup for the processor's 32-entry, 8-bit constant LUT: given a data value, returns the 5-bit address that holds it.
- Used by the assembler-visible "find constant" path and by self-check logic. The forward LUT maps address to data; this block maps data to address.
- Multi-cycle search engine with a start/done handshake, holding the same table image as the forward LUT.

Parameters:
- AW, 5, address width; table depth is 2**AW.
- DW, 8, data width.
- BASE, 60, value held in entry 0; entry i holds BASE+i.
- POPULATED, 14, number of initialised entries (0..POPULATED-1). Entries at or above POPULATED are invalid and never match.

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a search; sampled on rising clk, accepted only when busy=0.
- key  in  DW  value to find; captured on the accepting edge, ignored otherwise.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when a search completes.
- hit  out  1  result: 1 if key was found; valid from done, held until next done.
- index  out  AW  address of the matching entry; 0 on miss; held until next done.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, hit=0, index=0, internal pointer=0, key register=0.
- States:
  - IDLE: busy=0. On start: latch key, set ptr=0, go to SCAN.
  - SCAN: busy=1. Each cycle compares table[ptr] with the latched key.
    - Match: hit<=1, index<=ptr, go to DONE.
    - No match with ptr==POPULATED-1: hit<=0, index<=0, go to DONE.
    - Otherwise: ptr<=ptr+1.
  - DONE: done=1, busy=0, for exactly one cycle. start in this cycle is accepted (back-to-back): latch key, go to SCAN. Otherwise go to IDLE.
- Latency (start accepted at edge E0):
  - Match at entry k: done high after edge E(k+1), i.e. k+1 cycles.
  - Miss: done high after edge E(POPULATED), i.e. 14 cycles.
- The first matching (lowest) index wins. Table values are unique, so this matters only if parameters are changed.
- The comparison is a full DW-bit equality. Entries at or above POPULATED are never compared and the pointer never exceeds POPULATED-1, so there is no wrap-around.
- start while busy=1 is ignored; the latched key is unaffected.
- Changes on key after the accepting edge have no effect.
- Reset asserted mid-search aborts immediately to the reset values. No done pulse is produced for the aborted search.
- If POPULATED=0, SCAN takes one cycle and reports a miss.
- The table image is fixed at elaboration (entry i = BASE+i for i < POPULATED). It is not writable.

Optional Feature:
- Macro: MEM_LUT_SEARCH_ARITH_EN.
- Defined: the scan is replaced by a single-cycle arithmetic check. In SCAN:
  - hit = (key >= BASE) && (key - BASE < POPULATED), computed at DW+1 bits to avoid underflow.
  - index = key - BASE, truncated to AW bits, on hit; 0 on miss.
  - SCAN always lasts exactly one cycle, so done is high after E1 for every key.
- Undefined: the sequential scan above.
- The handshake, reset and hold rules are identical in both builds.

Test Plan:
- Reset, then key=60 with start at E0 -> done pulse after E1, hit=1, index=0, busy high for 1 cycle.
- key=73 -> done after E14, hit=1, index=13 (ARITH_EN build: after E1, index=13).
- key=59, then key=74 -> each done after E14 with hit=0, index=0 (ARITH_EN: after E1, same result).
- key=65 accepted; start with key=70 pulsed at E2 while busy -> ignored; done after E6 with index=5; hit/index held until the next done.
- Back-to-back: start during the DONE cycle with key=61 -> second search accepted, done 2 cycles later, index=1.
- rst_n pulled low during SCAN for key=72 -> busy/done/hit/index immediately 0, no done pulse; a new search for 62 then returns index=2.

Source files
------------

// File: rtl/mem_lut_search.sv
// Reverse lookup for the constant LUT: finds the address holding a given value.
// Optional macro MEM_LUT_SEARCH_ARITH_EN replaces the sequential scan with a one-cycle arithmetic check.
module mem_lut_search #(
    parameter int AW        = 5,
    parameter int DW        = 8,
    parameter int BASE      = 60,
    parameter int POPULATED = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [AW-1:0] index
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] key_q;
    logic          accept;
    logic          scan_end;
    logic          scan_hit;
    logic [AW-1:0] scan_index;

`ifdef MEM_LUT_SEARCH_ARITH_EN
    logic [DW:0] key_ext;
    logic [DW:0] diff;

    // Widened by one bit so keys below BASE cannot wrap into the valid range.
    always_comb begin
        key_ext    = {1'b0, key_q};
        diff       = key_ext - (DW+1)'(BASE);
        scan_hit   = (key_ext >= (DW+1)'(BASE)) && (diff < (DW+1)'(POPULATED));
        scan_index = scan_hit ? diff[AW-1:0] : '0;
        scan_end   = 1'b1;
    end
`else
    localparam int LAST = (POPULATED > 0) ? POPULATED - 1 : 0;

    logic [AW-1:0] ptr;
    logic [DW-1:0] entry;

    // The pointer never passes the last populated entry, so invalid entries are never compared.
    always_comb begin
        entry      = DW'(BASE + int'(ptr));
        scan_hit   = (POPULATED > 0) && (key_q == entry);
        scan_end   = scan_hit || (ptr == AW'(LAST));
        scan_index = scan_hit ? ptr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (accept)
            ptr <= '0;
        else if (state == SCAN && !scan_end)
            ptr <= ptr + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        accept    = start && (state != SCAN);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SCAN : IDLE;
            SCAN:    state_nxt = scan_end ? DONE : SCAN;
            DONE:    state_nxt = start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
        done = (state == DONE);
    end

    // Results are written only when a scan ends, so they hold across idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            hit   <= 1'b0;
            index <= '0;
        end else begin
            if (accept)
                key_q <= key;
            if (state == SCAN && scan_end) begin
                hit   <= scan_hit;
                index <= scan_index;
            end
        end
    end

endmodule
